// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32I instruction fetch stage.
// Opcodes, the NOP encoding and the fetch FSM state type.
package fetch_pkg;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, WAIT, KILL} fetch_state_t;
endpackage

// File: rtl/fetch_stage_imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended to size bits.
// Shared with the decoder; unknown opcodes yield zero.
module imm_gen
    import fetch_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [size-1:0] instr,
    output logic [size-1:0] imm
);
    logic [31:0] u_imm;

    assign u_imm = {instr[31:12], 12'b0};

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR:
                imm = {{(size-12){instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{(size-12){instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{(size-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {{(size-31){u_imm[31]}}, u_imm[30:0]};
            OPC_JAL:
                imm = {{(size-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end
endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC, single-outstanding imem fetch, branch prediction, IF/ID register.
// Define FETCH_BHT_EN to predict conditional branches with a 2-bit counter BHT instead of BTFN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              size      = 32,
    parameter logic [size-1:0] RESET_PC  = '0,
    parameter int              BHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            buble,
    input  logic            flush,
    input  logic [size-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [size-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [size-1:0] imem_rdata_i,
    input  logic            bp_update_i,
    input  logic [size-1:0] bp_update_pc_i,
    input  logic            bp_taken_i,
    output logic            valid_o,
    output logic [size-1:0] instruction_o,
    output logic [size-1:0] immediate_o,
    output logic [size-1:0] pc_plus_o,
    output logic [size-1:0] pc_value_at_prediction_o,
    output logic            branch_prediction_o
);
    localparam logic [size-1:0] FOUR = size'(4);

    fetch_state_t    state_q, state_d;
    logic [size-1:0] pc_q;
    logic            skid_full, skid_pred;
    logic [size-1:0] skid_instr, skid_pc;
    logic            granted, resp, pred_now, sel_pred, bht_pred;
    logic [size-1:0] sel_instr, sel_pc, sel_imm, next_pc;

    assign imem_req_o  = (state_q == REQ) && !skid_full && !reset;
    assign imem_addr_o = pc_q;
    assign granted     = imem_req_o && imem_gnt_i;
    assign resp        = (state_q == WAIT) && imem_rvalid_i;

    // A response only arrives with the skid empty, so the mux doubles as the live-response path.
    assign sel_instr = skid_full ? skid_instr : imem_rdata_i;
    assign sel_pc    = skid_full ? skid_pc : pc_q;

    imm_gen #(.size(size)) u_imm_gen (
        .instr (sel_instr),
        .imm   (sel_imm)
    );

    always_comb begin
        pred_now = 1'b0;
        case (imem_rdata_i[6:0])
            OPC_JAL:    pred_now = 1'b1;
            OPC_BRANCH: pred_now = bht_pred;
            default:    pred_now = 1'b0;
        endcase
    end

    assign next_pc  = pred_now ? pc_q + sel_imm : pc_q + FOUR;
    assign sel_pred = skid_full ? skid_pred : pred_now;

`ifdef FETCH_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] upd_idx;
    logic             unused_upd;

    assign upd_idx    = bp_update_pc_i[IDX_W+1:2];
    assign bht_pred   = bht_q[pc_q[IDX_W+1:2]][1];
    assign unused_upd = ^{bp_update_pc_i[size-1:IDX_W+2], bp_update_pc_i[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else if (bp_update_i) begin
            if (bp_taken_i && bht_q[upd_idx] != 2'b11)
                bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
            else if (!bp_taken_i && bht_q[upd_idx] != 2'b00)
                bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
        end
    end
`else
    logic unused_bp;

    assign unused_bp = ^{bp_update_i, bp_update_pc_i, bp_taken_i} ^ (BHT_DEPTH == 0);
    // Backward-taken / forward-not-taken: the sign of the branch offset.
    assign bht_pred  = sel_imm[size-1];
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ:     if (granted) state_d = flush ? KILL : WAIT;
            WAIT:    if (imem_rvalid_i) state_d = REQ;
                     else if (flush) state_d = KILL;
            KILL:    if (imem_rvalid_i) state_d = REQ;
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (flush)     pc_q <= redirect_pc_i;
            else if (resp) pc_q <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_o                  <= 1'b0;
            instruction_o            <= size'(NOP_INSTR);
            immediate_o              <= '0;
            pc_plus_o                <= '0;
            pc_value_at_prediction_o <= '0;
            branch_prediction_o      <= 1'b0;
            skid_full                <= 1'b0;
            skid_instr               <= '0;
            skid_pc                  <= '0;
            skid_pred                <= 1'b0;
        end else if (buble) begin
            if (resp) begin
                skid_full  <= 1'b1;
                skid_instr <= imem_rdata_i;
                skid_pc    <= pc_q;
                skid_pred  <= pred_now;
            end
        end else begin
            skid_full <= 1'b0;
            if (skid_full || resp) begin
                valid_o                  <= 1'b1;
                instruction_o            <= sel_instr;
                immediate_o              <= sel_imm;
                pc_plus_o                <= sel_pc + FOUR;
                pc_value_at_prediction_o <= sel_pc;
                branch_prediction_o      <= sel_pred;
            end else begin
                valid_o                  <= 1'b0;
                instruction_o            <= size'(NOP_INSTR);
                immediate_o              <= '0;
                pc_plus_o                <= '0;
                pc_value_at_prediction_o <= '0;
                branch_prediction_o      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage (default build): directed plan items plus random traffic
// checked against an instruction-stream reference model driven by a table-based memory.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset, buble, flush;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        bp_update_i, bp_taken_i;
    logic [31:0] bp_update_pc_i;
    logic        valid_o, branch_prediction_o;
    logic [31:0] instruction_o, immediate_o, pc_plus_o, pc_value_at_prediction_o;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset), .buble(buble), .flush(flush), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .bp_update_i(bp_update_i), .bp_update_pc_i(bp_update_pc_i), .bp_taken_i(bp_taken_i),
        .valid_o(valid_o), .instruction_o(instruction_o), .immediate_o(immediate_o),
        .pc_plus_o(pc_plus_o), .pc_value_at_prediction_o(pc_value_at_prediction_o),
        .branch_prediction_o(branch_prediction_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    // Memory image: word, its architectural immediate, kind (0 other, 1 branch, 2 jal).
    logic [31:0] mem_word [32];
    logic [31:0] mem_imm  [32];
    int          mem_kind [32];

    ent_t        exp_q[$];
    int          n_checks = 0, n_errors = 0;
    logic [31:0] model_pc;
    logic        out_pend = 1'b0, out_live = 1'b0;
    logic [31:0] out_addr = '0;
    int          out_cnt = 0;
    int          prev_kind = 0;  // 0 none, 1 cleared, 2 held, 3 load
    logic        last_valid;
    logic [31:0] last_instr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [11:0] imm);
        return {imm, 5'($urandom), 3'($urandom), 5'($urandom), opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm);
        return {imm[11:5], 5'($urandom), 5'($urandom), 3'($urandom), imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [12:0] regs);
        return {off[12], off[10:5], regs, off[4:1], off[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'($urandom), OPC_JAL};
    endfunction

    task automatic fill_mem();
        logic [11:0] i12;
        logic [19:0] u20;
        int          off;
        for (int i = 0; i < 32; i++) begin
            i12 = 12'($urandom);
            u20 = 20'($urandom);
            mem_kind[i] = 0;
            case ($urandom % 8)
                0: begin mem_word[i] = enc_i(OPC_OPIMM, i12); mem_imm[i] = 32'($signed(i12)); end
                1: begin mem_word[i] = enc_i(OPC_LOAD, i12);  mem_imm[i] = 32'($signed(i12)); end
                2: begin mem_word[i] = enc_i(OPC_JALR, i12);  mem_imm[i] = 32'($signed(i12)); end
                3: begin mem_word[i] = enc_s(i12);            mem_imm[i] = 32'($signed(i12)); end
                4: begin
                    off = (int'($urandom_range(0, 32)) - 16) * 4;
                    mem_word[i] = enc_b(13'(off), 13'($urandom));
                    mem_imm[i] = 32'(off); mem_kind[i] = 1;
                end
                5: begin
                    off = (int'($urandom_range(0, 64)) - 32) * 4;
                    mem_word[i] = enc_j(21'(off));
                    mem_imm[i] = 32'(off); mem_kind[i] = 2;
                end
                6: begin
                    mem_word[i] = {u20, 5'($urandom), ($urandom % 2 == 0) ? OPC_LUI : OPC_AUIPC};
                    mem_imm[i] = {u20, 12'b0};
                end
                default: begin mem_word[i] = {25'($urandom), 7'b0110011}; mem_imm[i] = '0; end
            endcase
        end
    endtask

    task automatic check_outputs();
        ent_t e;
        if (prev_kind == 1) begin
            chk("clr_valid", valid_o, 0);
            chk("clr_instr", instruction_o, NOP_INSTR);
            chk("clr_imm", immediate_o, 0);
            chk("clr_pc_plus", pc_plus_o, 0);
            chk("clr_pc", pc_value_at_prediction_o, 0);
            chk("clr_pred", branch_prediction_o, 0);
        end else if (prev_kind == 2) begin
            chk("hold_valid", valid_o, last_valid);
            chk("hold_instr", instruction_o, last_instr);
        end else if (prev_kind == 3) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid", valid_o, 1);
                chk("instr", instruction_o, e.instr);
                chk("imm", immediate_o, e.imm);
                chk("pc_plus", pc_plus_o, e.pc + 32'd4);
                chk("pc", pc_value_at_prediction_o, e.pc);
                chk("pred", branch_prediction_o, e.pred);
            end else begin
                chk("idle_valid", valid_o, 0);
                chk("idle_instr", instruction_o, NOP_INSTR);
            end
        end
        last_valid = valid_o;
        last_instr = instruction_o;
    endtask

    // One clock: check last edge's IF/ID, drive inputs, act as memory, advance the model.
    task automatic step(input logic rst, input logic b, input logic f, input logic [31:0] rpc,
                        input logic g, input int lat);
        logic rv, gn;
        ent_t e;
        int   idx;
        @(negedge clk);
        check_outputs();
        reset = rst; buble = b; flush = f; redirect_pc_i = rpc;
        rv = out_pend && out_cnt == 0;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word[out_addr[6:2]] : $urandom;
        #1;
        gn = imem_req_o && g && !out_pend;
        imem_gnt_i = gn;
        if (rst) chk("req_in_reset", imem_req_o, 0);
        else if (imem_req_o) begin
            chk("fetch_addr", imem_addr_o, model_pc);
            chk("req_with_skid", 32'(exp_q.size()), 0);
        end
        if (rv) begin
            out_pend = 1'b0;
            if (out_live && !f && !rst) begin
                idx     = int'(out_addr[6:2]);
                e.instr = mem_word[idx];
                e.imm   = mem_imm[idx];
                e.pc    = out_addr;
                e.pred  = (mem_kind[idx] == 2) || (mem_kind[idx] == 1 && mem_imm[idx][31]);
                exp_q.push_back(e);
                model_pc = e.pred ? out_addr + e.imm : out_addr + 32'd4;
            end
        end else if (out_pend && out_cnt > 0) out_cnt--;
        if (gn) begin
            out_pend = 1'b1; out_addr = imem_addr_o; out_cnt = lat - 1; out_live = !f;
        end
        if (rst) begin
            exp_q.delete(); model_pc = 32'h0; out_live = 1'b0;
        end else if (f) begin
            exp_q.delete(); model_pc = rpc; out_live = 1'b0;
        end
        prev_kind = (rst || f) ? 1 : (b ? 2 : 3);
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rpc;
        reset = 1'b1; buble = 1'b0; flush = 1'b0; redirect_pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        bp_update_i = 1'b0; bp_update_pc_i = '0; bp_taken_i = 1'b0;
        model_pc = '0;
        fill_mem();
        mem_word[0]  = 32'h0050_0093; mem_imm[0]  = 32'd5;          mem_kind[0]  = 0;
        mem_word[8]  = 32'hFE00_0CE3; mem_imm[8]  = 32'hFFFF_FFF8; mem_kind[8]  = 1;
        mem_word[16] = enc_j(21'h100); mem_imm[16] = 32'h100;       mem_kind[16] = 2;

        step(1, 0, 0, 0, 0, 1); step(1, 0, 0, 0, 0, 1);
        // addi x1, x0, 5 at 0x0
        step(0, 0, 0, 0, 1, 1); step(0, 0, 0, 0, 0, 1);
        #2; chk("addi_valid", valid_o, 1); chk("addi_imm", immediate_o, 5);
        chk("addi_pc_plus", pc_plus_o, 4); chk("addi_next", imem_addr_o, 32'h4);
        // backward beq at 0x20
        step(0, 0, 1, 32'h20, 0, 1); step(0, 0, 0, 0, 1, 1); step(0, 0, 0, 0, 0, 1);
        #2; chk("bwd_pred", branch_prediction_o, 1); chk("bwd_next", imem_addr_o, 32'h18);
        // forward beq at 0x20
        mem_word[8] = enc_b(13'd8, 13'd0); mem_imm[8] = 32'd8;
        step(0, 0, 1, 32'h20, 0, 1); step(0, 0, 0, 0, 1, 1); step(0, 0, 0, 0, 0, 1);
        #2; chk("fwd_pred", branch_prediction_o, 0); chk("fwd_next", imem_addr_o, 32'h24);
        // jal +0x100 at 0x40
        step(0, 0, 1, 32'h40, 0, 1); step(0, 0, 0, 0, 1, 1); step(0, 0, 0, 0, 0, 1);
        #2; chk("jal_next", imem_addr_o, 32'h140); chk("jal_imm", immediate_o, 32'h100);
        // three bubble cycles while the response lands
        step(0, 0, 0, 0, 1, 1); step(0, 1, 0, 0, 0, 1); step(0, 1, 0, 0, 0, 1); step(0, 1, 0, 0, 0, 1);
        #2; chk("skid_no_req", imem_req_o, 0); chk("skid_hold_valid", valid_o, 0);
        step(0, 0, 0, 0, 0, 1);
        #2; chk("skid_drain_valid", valid_o, 1); chk("skid_drain_pc", pc_value_at_prediction_o, 32'h140);
        // flush while waiting
        step(0, 0, 0, 0, 1, 2); step(0, 0, 1, 32'h80, 0, 1); step(0, 0, 0, 0, 0, 1);
        #2; chk("kill_valid", valid_o, 0); chk("kill_next", imem_addr_o, 32'h80);
        // flush together with bubble
        step(0, 0, 0, 0, 1, 2); step(0, 1, 1, 32'h80, 0, 1); step(0, 0, 0, 0, 0, 1);
        #2; chk("flush_buble_valid", valid_o, 0); chk("flush_buble_next", imem_addr_o, 32'h80);
        // reset in the middle of a transaction
        step(0, 0, 0, 0, 1, 2); step(1, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 1, 1);
        #2; chk("rst_mid_valid", valid_o, 0); chk("rst_mid_next", imem_addr_o, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            rpc = 32'($urandom_range(0, 1023)) << 2;
            step($urandom % 200 == 0, $urandom % 4 == 0, $urandom % 16 == 0, rpc,
                 $urandom % 3 != 0, int'($urandom_range(1, 3)));
        end
        for (int c = 0; c < 8; c++) step(0, 0, 0, 0, 0, 1);
        chk("drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction Fetch (IF) stage of the 5-stage RV32I pipeline. Sits directly upstream of the decode stage.
- Owns the PC and issues one-outstanding-request fetches to instruction memory.
- Performs static (optionally dynamic) branch prediction and generates the RV32I immediate.
- Drives the IF/ID pipeline register: instruction, immediate, pc+4, prediction PC, prediction bit.

Parameters:
size, 32, datapath/PC width
RESET_PC, 32'h0000_0000, first fetch address after reset
BHT_DEPTH, 64, BHT entries, power of 2; used only with FETCH_BHT_EN

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
buble  in  1  decode stall; hold IF/ID contents
flush  in  1  redirect from execute; kill all younger work
redirect_pc_i  in  size  new fetch PC, valid with flush
imem_req_o  out  1  fetch request valid
imem_addr_o  out  size  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid
imem_rdata_i  in  size  fetched instruction
bp_update_i  in  1  resolved conditional branch (BHT training)
bp_update_pc_i  in  size  PC of resolved branch
bp_taken_i  in  1  actual outcome
valid_o  out  1  IF/ID holds a real instruction
instruction_o  out  size  IF/ID instruction
immediate_o  out  size  sign-extended immediate
pc_plus_o  out  size  instruction PC + 4
pc_value_at_prediction_o  out  size  instruction PC
branch_prediction_o  out  1  predicted taken

Behaviour:
- Reset:
  - pc_q = RESET_PC.
  - FSM = REQ.
  - All IF/ID outputs 0, except instruction_o = 32'h0000_0013 (NOP).
  - Skid buffer empty.
  - imem_req_o = 0 during the reset cycle.
  - Reset asserted mid-transaction abandons the transaction; any later rvalid is ignored until a new grant.
- FSM states:
  - REQ: imem_req_o = 1 and imem_addr_o = pc_q, but only if the skid buffer is empty. On imem_gnt_i -> WAIT.
  - WAIT: imem_req_o = 0. On imem_rvalid_i, process the response, then -> REQ.
  - KILL: entered from WAIT on flush. Drop the next rvalid, then -> REQ.
- Flush in REQ (gnt or not): pc_q = redirect_pc_i and stay in REQ. A request granted in that same cycle is treated as killed, i.e. the FSM goes to KILL.
- Response processing (opcode = rdata[6:0]):
  - JAL (1101111): predict taken; target = pc + immJ.
  - BRANCH (1100011): predict taken iff immB[31] = 1 (backward-taken/forward-not-taken); target = pc + immB.
  - All others, including JALR: not taken; next pc = pc + 4.
  - pc_q is updated to the predicted next PC in the response cycle. Adders are modulo 2^size.
- Immediate formats, selected by opcode:
  - I: load, OP-IMM, JALR.
  - S: store.
  - B: branch.
  - U: LUI, AUIPC.
  - J: JAL.
  - Otherwise 0.
- IF/ID register:
  - Loads on response when buble = 0 and flush = 0; valid_o = 1.
  - If buble = 1, the response goes into the 1-entry skid buffer. The skid drains into IF/ID on the first cycle with buble = 0.
  - With buble = 0 and no new data, valid_o = 0 and instruction_o = NOP.
  - No new request is issued while the skid buffer is full.
- Flush:
  - Highest priority (flush + buble: flush wins).
  - Clears IF/ID to the reset values and empties the skid buffer.
  - Sets pc_q = redirect_pc_i; the first request goes out the next cycle.
- Latency: grant with rvalid one cycle later gives valid_o one cycle after rvalid. Throughput is one instruction per 2 cycles minimum.

Optional Feature:
- Macro: FETCH_BHT_EN.
- Defined:
  - Conditional branches are predicted by a BHT_DEPTH-entry table of 2-bit counters, indexed by pc[log2(BHT_DEPTH)+1:2], reset to 2'b01.
  - Predict taken when counter[1] = 1.
  - bp_update_i saturating-increments the counter when bp_taken_i = 1, otherwise decrements it.
  - An update and a lookup to the same index in the same cycle use the old value.
- Undefined: static BTFN only; the bp_* ports are ignored.

Decomposition:
- Package fetch_pkg holds:
  - Opcode constants: OPC_JAL, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_JALR, OPC_LUI, OPC_AUIPC.
  - NOP_INSTR = 32'h0000_0013.
  - fetch_state_t enum {REQ, WAIT, KILL}.
- Sub-module imm_gen: combinational immediate extraction, reusable by the decoder.

Test Plan:
- Reset then gnt/rvalid each 1 cycle, memory returns addi x1, x0, 5 at 0x0 -> valid_o = 1, immediate_o = 5, pc_plus_o = 4; next imem_addr_o = 0x4.
- Fetch at 0x20 returns beq with offset -8 (0xFE000CE3) -> branch_prediction_o = 1, next imem_addr_o = 0x18; with offset +8 -> prediction 0, next address 0x24.
- JAL x0, +0x100 fetched at 0x40 -> next imem_addr_o = 0x140, immediate_o = 0x100.
- buble held 3 cycles while a response arrives -> IF/ID unchanged, skid full, imem_req_o = 0; on release the instruction appears the next cycle in order.
- flush with redirect_pc_i = 0x80 while in WAIT -> the late rvalid is dropped, valid_o = 0, next request address = 0x80; flush + buble together -> flush behaviour.
- FETCH_BHT_EN: two bp_update_i not-taken at 0x20 -> a backward branch at 0x20 is predicted not taken; two taken updates -> predicted taken.
